// File: rtl/mc_pkg.sv
// mc_pkg: shared opcodes, state encoding, datapath select encodings and ALU codes
// for the multi-cycle sequencer; the dispatch helper honours MC_SEQ_MULDIV_EN.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD, S_MEM_WR,
      S_WB_ALU, S_WB_MEM, S_BRANCH, S_JUMP, S_MD_START, S_MD_WAIT, S_TRAP
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_IMM_A = 6'h01;
   localparam logic [5:0] OP_IMM_B = 6'h07;
   localparam logic [5:0] OP_LW    = 6'h04;
   localparam logic [5:0] OP_SW    = 6'h05;
   localparam logic [5:0] OP_BEQ   = 6'h06;
   localparam logic [5:0] OP_BR_LO = 6'h08;
   localparam logic [5:0] OP_BR_HI = 6'h0D;
   localparam logic [5:0] OP_J     = 6'h0E;
   localparam logic [5:0] OP_IMUL  = 6'h0F;
   localparam logic [5:0] OP_DIVI  = 6'h10;

   localparam logic [1:0] B_REG   = 2'd0;
   localparam logic [1:0] B_FOUR  = 2'd1;
   localparam logic [1:0] B_IMM   = 2'd2;
   localparam logic [1:0] B_SHIMM = 2'd3;

   localparam logic [1:0] PC_ALU    = 2'd0;
   localparam logic [1:0] PC_ALUOUT = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   localparam logic [5:0] ALU_ADD  = 6'd0;
   localparam logic [5:0] ALU_SUB  = 6'd1;
   localparam logic [5:0] ALU_IMM  = 6'd2;
   localparam logic [5:0] ALU_ADDR = 6'd3;
   localparam logic [5:0] ALU_BR8  = 6'd8;
   localparam logic [5:0] ALU_BR9  = 6'd9;
   localparam logic [5:0] ALU_BR10 = 6'd10;
   localparam logic [5:0] ALU_BR11 = 6'd11;
   localparam logic [5:0] ALU_BR12 = 6'd12;
   localparam logic [5:0] ALU_BR13 = 6'd13;
   localparam logic [5:0] ALU_JUMP = 6'd14;
   localparam logic [5:0] ALU_PASS = 6'd15;

   function automatic state_t decode_next(input logic [5:0] op);
      if (op == OP_RTYPE) return S_EXEC_R;
      if (op inside {OP_IMM_A, OP_IMM_B}) return S_EXEC_I;
      if (op inside {OP_LW, OP_SW}) return S_MEM_ADDR;
      if (op inside {OP_BEQ, [OP_BR_LO:OP_BR_HI]}) return S_BRANCH;
      if (op == OP_J) return S_JUMP;
`ifdef MC_SEQ_MULDIV_EN
      if (op inside {OP_IMUL, OP_DIVI}) return S_MD_START;
`endif
      return S_TRAP;
   endfunction

endpackage

// File: rtl/mc_md_timer.sv
// mc_md_timer: counts MD_WAIT cycles and flags the last permitted one.
module mc_md_timer
   import mc_pkg::*;
#(
   parameter int MD_TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_inc,
   output logic o_last
);

   localparam int W = (MD_TIMEOUT > 1) ? $clog2(MD_TIMEOUT) : 1;

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (rst || i_clear) r_cnt <= '0;
      else if (i_inc) r_cnt <= r_cnt + W'(1);
   end

   assign o_last = (r_cnt == W'(MD_TIMEOUT - 1));

endmodule

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle CPU control FSM with outputs decoded from state and opcode.
// Optional mul/div sequencing (MD_START/MD_WAIT, timeout counter) under MC_SEQ_MULDIV_EN.
module mc_sequencer
   import mc_pkg::*;
#(
   parameter int MD_TIMEOUT = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   input  logic       md_done,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       ir_write,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       reg_write,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] pc_src,
   output logic [5:0] alu_op,
   output logic       md_start,
   output logic       md_op,
   output logic       illegal,
   output logic [3:0] state
);

   state_t r_state;

`ifdef MC_SEQ_MULDIV_EN
   logic w_md_last;

   mc_md_timer #(.MD_TIMEOUT(MD_TIMEOUT)) u_timer (
      .clk     (clk),
      .rst     (rst),
      .i_clear (r_state == S_MD_START),
      .i_inc   (r_state == S_MD_WAIT),
      .o_last  (w_md_last)
   );
`endif

   always_ff @(posedge clk) begin
      if (rst) r_state <= S_FETCH;
      else begin
         case (r_state)
            S_FETCH:    if (mem_ready) r_state <= S_DECODE;
            S_DECODE:   r_state <= decode_next(opcode);
            S_EXEC_R:   r_state <= S_WB_ALU;
            S_EXEC_I:   r_state <= S_WB_ALU;
            S_MEM_ADDR: r_state <= (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:   if (mem_ready) r_state <= S_WB_MEM;
            S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
            S_WB_ALU:   r_state <= S_FETCH;
            S_WB_MEM:   r_state <= S_FETCH;
            S_BRANCH:   r_state <= S_FETCH;
            S_JUMP:     r_state <= S_FETCH;
`ifdef MC_SEQ_MULDIV_EN
            S_MD_START: r_state <= S_MD_WAIT;
            // a result on the final count wins over the timeout
            S_MD_WAIT:  r_state <= md_done ? S_WB_ALU : (w_md_last ? S_TRAP : S_MD_WAIT);
`endif
            default:    r_state <= S_TRAP;
         endcase
      end
   end

   always_comb begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = B_REG;
      pc_src        = PC_ALU;
      alu_op        = ALU_ADD;
      md_start      = 1'b0;
      md_op         = 1'b0;
      case (r_state)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = B_FOUR;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE:   alu_src_b = B_SHIMM;
         S_EXEC_R:   alu_src_a = 1'b1;
         S_EXEC_I: begin
            alu_src_a = 1'b1;
            alu_src_b = B_IMM;
            alu_op    = ALU_IMM;
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = B_IMM;
            alu_op    = ALU_ADDR;
         end
         S_MEM_RD: begin
            iord     = 1'b1;
            mem_read = 1'b1;
         end
         S_MEM_WR: begin
            iord      = 1'b1;
            mem_write = 1'b1;
         end
         S_WB_ALU: begin
            reg_write = 1'b1;
            reg_dst   = opcode inside {OP_RTYPE, OP_IMUL, OP_DIVI};
         end
         S_WB_MEM: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_BRANCH: begin
            pc_write_cond = 1'b1;
            alu_src_a     = 1'b1;
            pc_src        = PC_ALUOUT;
            alu_op        = (opcode == OP_BEQ) ? ALU_SUB : opcode;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            alu_op   = ALU_JUMP;
         end
`ifdef MC_SEQ_MULDIV_EN
         S_MD_START: begin
            md_start  = 1'b1;
            md_op     = opcode[4];
            alu_src_a = 1'b1;
            alu_src_b = B_IMM;
         end
         S_MD_WAIT:  md_op = opcode[4];
`endif
         default: ;
      endcase
      if (rst) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         ir_write      = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         reg_write     = 1'b0;
         md_start      = 1'b0;
      end
   end

   assign illegal = (r_state == S_TRAP);
   assign state   = r_state;

endmodule
